// File: rtl/ps2_key_latch.sv
// rtl/ps2_key_latch.sv - PS/2 frame receiver and make/break decoder holding the pressed key's scan code
module ps2_key_latch #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       Pixelclock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] character,
    output logic       new_key,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_edge;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] to_cnt_q;
    logic          brk_q, ext_q;
    logic [7:0]    char_q;
    logic          new_key_q, frame_err_q;

    // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1
    always_ff @(posedge Pixelclock or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filter: count consecutive samples that disagree with the filtered level
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    // The falling edge is flagged in the same cycle the filter commits to 0
    assign fall_edge = filt_q & ~clk_s2_q & (filt_cnt_q == FW'(FILTER_LEN - 1));

    // Filter state registers
    always_ff @(posedge Pixelclock or posedge reset) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // Frame FSM with timeout and scan-code decoder; all outputs registered
    always_ff @(posedge Pixelclock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            char_q      <= 8'h00;
            new_key_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            new_key_q   <= 1'b0;
            frame_err_q <= 1'b0;

            if (state_q == IDLE || fall_edge) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end

            if (fall_edge) begin
                case (state_q)
                    IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= dat_s2_q;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if ((^{shift_q, parity_q}) && dat_s2_q) begin
                            if (shift_q == 8'hF0) begin
                                brk_q <= 1'b1;
                            end else if (shift_q == 8'hE0) begin
                                ext_q <= 1'b1;
                            end else if (ext_q) begin
                                // Extended keys are not rendered; drop the code
                                ext_q <= 1'b0;
                                brk_q <= 1'b0;
                            end else if (brk_q) begin
                                if (shift_q == char_q) begin
                                    char_q <= 8'h00;
                                end
                                brk_q <= 1'b0;
                            end else begin
                                char_q    <= shift_q;
                                new_key_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                // A stop-bit edge in this cycle takes the branch above instead
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
            end
        end
    end

    assign character = char_q;
    assign new_key   = new_key_q;
    assign frame_err = frame_err_q;

endmodule
